// File: rtl/data_memory_be.sv
// -----------------------------------------------------------------------------
// data_memory_be
//   Data memory for the MIPS MEM stage. It accepts one access per cycle and
//   supports per-byte write lanes, a read latency of 1 or 2 cycles with a
//   read-valid strobe, an optional zero-fill sequence after reset, and a
//   one-cycle error pulse on an illegal access.
//
// Parameters
//   DATA_WIDTH   word width in bits (multiple of 8)
//   ADDR_WIDTH   word address width; DEPTH = 2**ADDR_WIDTH
//   READ_LATENCY 1 or 2 (any value other than 2 behaves as 1)
//   INIT_ZERO    1: zero every word after reset before accepting accesses
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   address  in   word address of the access
//   data     in   write data
//   byteen   in   byte-lane write mask; bit i covers data[8i+7:8i]
//   rden     in   read request, sampled at posedge
//   wren     in   write request, sampled at posedge
//   q        out  read data; holds its last value while q_valid=0
//   q_valid  out  one-cycle strobe marking q as the requested word
//   busy     out  high while the zero-fill runs
//   err      out  one-cycle pulse after an illegal access
// -----------------------------------------------------------------------------
module data_memory_be #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int INIT_ZERO    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [DATA_WIDTH/8-1:0] byteen,
    input  logic                    rden,
    input  logic                    wren,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    q_valid,
    output logic                    busy,
    output logic                    err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   q_q;
    logic                    q_valid_q;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // Shared write port: the fill sequencer and normal writes never overlap.
    logic                    rd_fire;
    logic [NB-1:0]           wr_lane;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        err_d      = 1'b0;
        rd_fire    = 1'b0;
        wr_lane    = '0;
        wr_addr    = address;
        wr_data    = data;
        case (state_q)
            ST_INIT: begin
                wr_lane    = '1;
                wr_addr    = init_cnt_q;
                wr_data    = '0;
                init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_READY;
                end
                // Any request while filling is dropped and flagged.
                err_d = rden | wren;
            end
            default: begin
                // Simultaneous read and write: write wins, read is dropped.
                rd_fire = rden & ~wren;
                if (wren) begin
                    wr_lane = byteen;
                end
                err_d = rden & wren;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
            init_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            err_q      <= err_d;
        end
    end

    // Array has no reset; writes are held off while rst_n is low so that
    // reset alone never changes the contents.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_lane[i]) begin
                    mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] rd_data_p1_q;
            logic                  rd_vld_p1_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_p1_q <= '0;
                    rd_vld_p1_q  <= 1'b0;
                    q_q          <= '0;
                    q_valid_q    <= 1'b0;
                end else begin
                    rd_vld_p1_q <= rd_fire;
                    if (rd_fire) begin
                        rd_data_p1_q <= mem_q[address];
                    end
                    q_valid_q <= rd_vld_p1_q;
                    if (rd_vld_p1_q) begin
                        q_q <= rd_data_p1_q;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_q       <= '0;
                    q_valid_q <= 1'b0;
                end else begin
                    q_valid_q <= rd_fire;
                    if (rd_fire) begin
                        q_q <= mem_q[address];
                    end
                end
            end
        end
    endgenerate

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign busy    = (state_q == ST_INIT);
    assign err     = err_q;

endmodule
